// File: rtl/gcd_result_handshake_if.sv
// Result-side bus of the GCD block: datapath result input, four-phase
// req/ack pins toward the external receiver, and drop status.
interface gcd_result_handshake_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DROP_W = 8
) ();
  logic              result_valid_i;
  logic [WIDTH-1:0]  result_i;
  logic              result_ready_o;
  logic              req_o;
  logic [WIDTH-1:0]  data_o;
  logic              ack_i;
  logic              overflow_o;
  logic [DROP_W-1:0] drop_cnt_o;

  // Handshake transmitter (the block itself).
  modport master (
    input  result_valid_i,
    input  result_i,
    output result_ready_o,
    output req_o,
    output data_o,
    input  ack_i,
    output overflow_o,
    output drop_cnt_o
  );

  // Environment: GCD datapath plus external receiver.
  modport slave (
    output result_valid_i,
    output result_i,
    input  result_ready_o,
    input  req_o,
    input  data_o,
    output ack_i,
    input  overflow_o,
    input  drop_cnt_o
  );
endinterface

// File: rtl/gcd_result_handshake.sv
// Captures each GCD result and presents it on a held-stable bus under a
// four-phase req/ack handshake; ack is synchronised from a foreign domain.
// Results arriving while not ready are dropped and counted (saturating).
module gcd_result_handshake #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DROP_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  gcd_result_handshake_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

  logic ack_sync;
  logic ready;
  logic accept;
  logic drop;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  // A stale ack held in IDLE blocks acceptance, so ready reflects it too.
  assign ready    = (state_q == IDLE) && !ack_sync;
  assign accept   = bus.result_valid_i && ready;
  assign drop     = bus.result_valid_i && !ready;

  // Shift raw ack into the synchroniser chain.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.ack_i};
  end

  // Next-state and registered-output logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.result_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ack_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // State and output registers; reset aborts any handshake immediately.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign bus.result_ready_o = ready;
  assign bus.req_o          = req_q;
  assign bus.data_o         = data_q;
  assign bus.overflow_o     = overflow_q;
  assign bus.drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_gcd_result_handshake.sv
// Directed bench: u0 (DROP_W=8) covers reset, transfers, drops and the
// WAIT_LOW exit boundary; u1 (DROP_W=2) covers counter saturation.
module tb_gcd_result_handshake;

  logic clk_i;
  logic nreset_i;

  int unsigned checks;
  int unsigned errors;

  gcd_result_handshake_if #(.WIDTH(16), .DROP_W(8)) bus0 ();
  gcd_result_handshake_if #(.WIDTH(16), .DROP_W(2)) bus1 ();

  gcd_result_handshake #(
    .WIDTH(16), .SYNC_STAGES(2), .DROP_W(8)
  ) u0 (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .bus      (bus0)
  );

  gcd_result_handshake #(
    .WIDTH(16), .SYNC_STAGES(2), .DROP_W(2)
  ) u1 (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .bus      (bus1)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nreset_i = 1'b0;
    bus0.result_valid_i = 1'b0; bus0.result_i = '0; bus0.ack_i = 1'b1;
    bus1.result_valid_i = 1'b0; bus1.result_i = '0; bus1.ack_i = 1'b0;

    // 1. reset with ack held high
    #12;
    check("rst_ready", 32'(bus0.result_ready_o), 32'd1);
    check("rst_req",   32'(bus0.req_o),          32'd0);
    check("rst_data",  32'(bus0.data_o),         32'h0);
    check("rst_ovf",   32'(bus0.overflow_o),     32'd0);
    check("rst_cnt",   32'(bus0.drop_cnt_o),     32'd0);
    tick(1);
    nreset_i = 1'b1;
    tick(2);
    check("stale_ack_ready", 32'(bus0.result_ready_o), 32'd0);
    check("stale_ack_req",   32'(bus0.req_o),          32'd0);
    bus0.ack_i = 1'b0;
    tick(1);
    check("ack_low1_ready", 32'(bus0.result_ready_o), 32'd0);
    tick(1);
    check("ack_low2_ready", 32'(bus0.result_ready_o), 32'd1);

    // 2. single transfer 0x0015
    bus0.result_valid_i = 1'b1; bus0.result_i = 16'h0015;
    tick(1);
    bus0.result_valid_i = 1'b0; bus0.result_i = 16'h0000;
    check("t2_req",   32'(bus0.req_o),          32'd1);
    check("t2_data",  32'(bus0.data_o),         32'h0015);
    check("t2_ready", 32'(bus0.result_ready_o), 32'd0);
    bus0.ack_i = 1'b1;
    tick(2);
    check("t2_req_held", 32'(bus0.req_o), 32'd1);
    tick(1);
    check("t2_req_fall", 32'(bus0.req_o), 32'd0);
    check("t2_data_wl",  32'(bus0.data_o), 32'h0015);
    bus0.ack_i = 1'b0;
    tick(2);
    check("t2_ready_wl", 32'(bus0.result_ready_o), 32'd0);
    tick(1);
    check("t2_ready_back", 32'(bus0.result_ready_o), 32'd1);
    check("t2_data_end",   32'(bus0.data_o),         32'h0015);
    check("t2_cnt",        32'(bus0.drop_cnt_o),     32'd0);

    // 3. drop during handshake
    bus0.result_valid_i = 1'b1; bus0.result_i = 16'h0007;
    tick(1);
    bus0.result_i = 16'h0003;
    tick(1);
    bus0.result_valid_i = 1'b0;
    check("t3_data", 32'(bus0.data_o),     32'h0007);
    check("t3_ovf",  32'(bus0.overflow_o), 32'd1);
    check("t3_cnt",  32'(bus0.drop_cnt_o), 32'd1);
    check("t3_req",  32'(bus0.req_o),      32'd1);
    bus0.ack_i = 1'b1;
    tick(3);
    check("t3_req_fall", 32'(bus0.req_o), 32'd0);
    bus0.ack_i = 1'b0;
    tick(3);
    check("t3_ready", 32'(bus0.result_ready_o), 32'd1);
    check("t3_data_end", 32'(bus0.data_o), 32'h0007);

    // 4. pulse on the WAIT_LOW exit cycle is a drop; one cycle later accepted
    bus0.result_valid_i = 1'b1; bus0.result_i = 16'h0011;
    tick(1);
    bus0.result_valid_i = 1'b0;
    bus0.ack_i = 1'b1;
    tick(3);
    check("t4_req_fall", 32'(bus0.req_o), 32'd0);
    bus0.ack_i = 1'b0;
    tick(2);
    check("t4_exit_ready", 32'(bus0.result_ready_o), 32'd0);
    bus0.result_valid_i = 1'b1; bus0.result_i = 16'h0022;
    tick(1);
    check("t4_exit_drop", 32'(bus0.drop_cnt_o),     32'd2);
    check("t4_exit_data", 32'(bus0.data_o),         32'h0011);
    check("t4_ready_now", 32'(bus0.result_ready_o), 32'd1);
    tick(1);
    bus0.result_valid_i = 1'b0;
    check("t4_accept_req",  32'(bus0.req_o),      32'd1);
    check("t4_accept_data", 32'(bus0.data_o),     32'h0022);
    check("t4_accept_cnt",  32'(bus0.drop_cnt_o), 32'd2);
    bus0.ack_i = 1'b1;
    tick(3);
    bus0.ack_i = 1'b0;
    tick(3);
    check("t4_ready_end", 32'(bus0.result_ready_o), 32'd1);

    // 5. saturation on the DROP_W=2 instance
    bus1.result_valid_i = 1'b1; bus1.result_i = 16'h000A;
    tick(1);
    bus1.result_i = 16'h000B;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("t5_cnt%0d", i), 32'(bus1.drop_cnt_o), (i < 2) ? 32'(i + 1) : 32'd3);
    end
    bus1.result_valid_i = 1'b0;
    check("t5_ovf",  32'(bus1.overflow_o), 32'd1);
    check("t5_data", 32'(bus1.data_o),     32'h000A);
    check("t5_req",  32'(bus1.req_o),      32'd1);

    // 6. asynchronous reset mid-handshake
    bus0.result_valid_i = 1'b1; bus0.result_i = 16'h0033;
    tick(1);
    bus0.result_valid_i = 1'b0;
    check("t6_req_pre", 32'(bus0.req_o), 32'd1);
    #2 nreset_i = 1'b0;
    #1;
    check("t6_rst_req",  32'(bus0.req_o),      32'd0);
    check("t6_rst_data", 32'(bus0.data_o),     32'h0);
    check("t6_rst_ovf",  32'(bus0.overflow_o), 32'd0);
    check("t6_rst_cnt",  32'(bus0.drop_cnt_o), 32'd0);
    check("t6_rst_u1cnt", 32'(bus1.drop_cnt_o), 32'd0);
    tick(1);
    nreset_i = 1'b1;
    tick(1);
    check("t6_ready", 32'(bus0.result_ready_o), 32'd1);
    bus0.result_valid_i = 1'b1; bus0.result_i = 16'hFFFF;
    tick(1);
    bus0.result_valid_i = 1'b0;
    check("t6_req",  32'(bus0.req_o),  32'd1);
    check("t6_data", 32'(bus0.data_o), 32'hFFFF);
    bus0.ack_i = 1'b1;
    tick(3);
    check("t6_req_fall", 32'(bus0.req_o), 32'd0);
    bus0.ack_i = 1'b0;
    tick(3);
    check("t6_ready_end", 32'(bus0.result_ready_o), 32'd1);
    check("t6_data_end",  32'(bus0.data_o),         32'hFFFF);
    check("t6_cnt_end",   32'(bus0.drop_cnt_o),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
